data_mem_responder: RTL

// Responder end of the EX-stage data request interface: accepts load/store/AMO requests, runs them on a

---
 rtl/data_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Responder for EX-stage data requests: loads, stores, RV32A AMOs and LR/SC
// over a single-outstanding memory bus, with lane steering and an ack timeout.
//
// state | meaning
// IDLE  | ready for a new request, outputs hold the last result
// RD    | read beat outstanding (load, LR, AMO old-value fetch)
// WR    | write beat (store, SC, AMO); for AMO the first WR cycle has MEM_REQ low
module data_mem_responder #(
  parameter bit RESERVATION_EN = 1'b1,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA_ADDRESS,
  input  logic [31:0] DATA_IN,
  input  logic [1:0]  DATA_CACHE_CONTROL,
  input  logic [1:0]  TYPE_IN,
  input  logic [2:0]  FUN3,
  input  logic        AMO_VALID,
  input  logic [4:0]  AMO_OP,
  output logic        CACHE_READY,
  output logic [31:0] DATA_OUT,
  output logic        MISALIGNED,
  output logic        BUS_ERR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_WSTRB,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  // last count value before the timeout fires; only meaningful when ACK_TIMEOUT != 0
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wsrc_q, wsrc_d;
  logic [1:0]  type_q, type_d;
  logic        zext_q, zext_d;
  logic        amo_q, amo_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] old_q, old_d;
  logic        resv_valid_q, resv_valid_d;
  logic [29:0] resv_addr_q, resv_addr_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic        ready_d, mis_d, berr_d, req_d, we_d;
  logic [31:0] dout_d, maddr_d, wdata_d;
  logic [3:0]  wstrb_d;

  logic        req_valid, is_store, misalign_in, resv_hit;
  logic [31:0] store_data;
  logic [3:0]  store_strb;

  logic unused_fun3;
  assign unused_fun3 = ^FUN3[1:0];

  // sign/zero-extend the addressed lane of a read word
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] lane,
                                              input logic [1:0] typ, input logic zext);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (typ)
      2'b00:   load_extend = zext ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extend = zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  // read-modify-write result; unrecognised funct5 behaves as SWAP
  function automatic logic [31:0] amo_calc(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      OP_ADD:  amo_calc = a + b;
      OP_XOR:  amo_calc = a ^ b;
      OP_AND:  amo_calc = a & b;
      OP_OR:   amo_calc = a | b;
      OP_MIN:  amo_calc = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  amo_calc = ($signed(a) > $signed(b)) ? a : b;
      OP_MINU: amo_calc = (a < b) ? a : b;
      OP_MAXU: amo_calc = (a > b) ? a : b;
      default: amo_calc = b;
    endcase
  endfunction

  // request decode, alignment check and store lane steering
  always_comb begin
    req_valid  = AMO_VALID || (DATA_CACHE_CONTROL == 2'b01) || (DATA_CACHE_CONTROL == 2'b10);
    is_store   = !AMO_VALID && (DATA_CACHE_CONTROL == 2'b01);
    resv_hit   = RESERVATION_EN && resv_valid_q && (resv_addr_q == DATA_ADDRESS[31:2]);
    store_data = DATA_IN;
    store_strb = 4'hF;
    if (AMO_VALID) begin
      misalign_in = (DATA_ADDRESS[1:0] != 2'b00) || !TYPE_IN[1];
    end else begin
      case (TYPE_IN)
        2'b00:   misalign_in = 1'b0;
        2'b01:   misalign_in = DATA_ADDRESS[0];
        default: misalign_in = (DATA_ADDRESS[1:0] != 2'b00);
      endcase
    end
    case (TYPE_IN)
      2'b00: begin
        store_data = {4{DATA_IN[7:0]}};
        store_strb = 4'b0001 << DATA_ADDRESS[1:0];
      end
      2'b01: begin
        store_data = {2{DATA_IN[15:0]}};
        store_strb = 4'b0011 << DATA_ADDRESS[1:0];
      end
      default: ;
    endcase
  end

  // next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wsrc_d       = wsrc_q;
    type_d       = type_q;
    zext_d       = zext_q;
    amo_d        = amo_q;
    op_d         = op_q;
    old_d        = old_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    tcnt_d       = tcnt_q;
    ready_d      = CACHE_READY;
    dout_d       = DATA_OUT;
    mis_d        = MISALIGNED;
    berr_d       = BUS_ERR;
    req_d        = MEM_REQ;
    we_d         = MEM_WE;
    maddr_d      = MEM_ADDR;
    wdata_d      = MEM_WDATA;
    wstrb_d      = MEM_WSTRB;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = DATA_ADDRESS;
          wsrc_d  = DATA_IN;
          type_d  = TYPE_IN;
          zext_d  = FUN3[2];
          amo_d   = AMO_VALID;
          op_d    = AMO_OP;
          tcnt_d  = 16'd0;
          mis_d   = misalign_in;
          berr_d  = 1'b0;
          maddr_d = {DATA_ADDRESS[31:2], 2'b00};
          if (misalign_in) begin
            dout_d  = 32'd0;
            maddr_d = MEM_ADDR;
          end else if (AMO_VALID && AMO_OP == OP_SC) begin
            resv_valid_d = 1'b0;
            if (resv_hit) begin
              state_d = WR;
              ready_d = 1'b0;
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = DATA_IN;
              wstrb_d = 4'hF;
            end else begin
              dout_d  = 32'd1;
              maddr_d = MEM_ADDR;
            end
          end else if (AMO_VALID || !is_store) begin
            if (AMO_VALID && AMO_OP != OP_LR && resv_hit) resv_valid_d = 1'b0;
            state_d = RD;
            ready_d = 1'b0;
            req_d   = 1'b1;
            we_d    = 1'b0;
            wstrb_d = 4'h0;
          end else begin
            if (resv_hit) resv_valid_d = 1'b0;
            state_d = WR;
            ready_d = 1'b0;
            req_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = store_data;
            wstrb_d = store_strb;
          end
        end
      end

      RD: begin
        if (MEM_ACK) begin
          tcnt_d = 16'd0;
          req_d  = 1'b0;
          if (amo_q && op_q != OP_LR) begin
            old_d   = MEM_RDATA;
            state_d = WR;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
            if (amo_q) begin
              dout_d = MEM_RDATA;
              if (RESERVATION_EN) begin
                resv_valid_d = 1'b1;
                resv_addr_d  = addr_q[31:2];
              end
            end else begin
              dout_d = load_extend(MEM_RDATA, addr_q[1:0], type_q, zext_q);
            end
          end
        end else if (ACK_TIMEOUT != 0 && tcnt_q == TO_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          dout_d  = 32'd0;
          tcnt_d  = 16'd0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      WR: begin
        if (!MEM_REQ) begin
          // AMO write beat starts after the one-cycle gap following the read
          req_d   = 1'b1;
          we_d    = 1'b1;
          wdata_d = amo_calc(op_q, old_q, wsrc_q);
          wstrb_d = 4'hF;
        end else if (MEM_ACK) begin
          tcnt_d  = 16'd0;
          req_d   = 1'b0;
          state_d = IDLE;
          ready_d = 1'b1;
          if (amo_q) dout_d = (op_q == OP_SC) ? 32'd0 : old_q;
        end else if (ACK_TIMEOUT != 0 && tcnt_q == TO_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          dout_d  = 32'd0;
          tcnt_d  = 16'd0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // state, request context and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      wsrc_q       <= 32'd0;
      type_q       <= 2'd0;
      zext_q       <= 1'b0;
      amo_q        <= 1'b0;
      op_q         <= 5'd0;
      old_q        <= 32'd0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= 30'd0;
      tcnt_q       <= 16'd0;
      CACHE_READY  <= 1'b1;
      DATA_OUT     <= 32'd0;
      MISALIGNED   <= 1'b0;
      BUS_ERR      <= 1'b0;
      MEM_REQ      <= 1'b0;
      MEM_WE       <= 1'b0;
      MEM_ADDR     <= 32'd0;
      MEM_WDATA    <= 32'd0;
      MEM_WSTRB    <= 4'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wsrc_q       <= wsrc_d;
      type_q       <= type_d;
      zext_q       <= zext_d;
      amo_q        <= amo_d;
      op_q         <= op_d;
      old_q        <= old_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
      tcnt_q       <= tcnt_d;
      CACHE_READY  <= ready_d;
      DATA_OUT     <= dout_d;
      MISALIGNED   <= mis_d;
      BUS_ERR      <= berr_d;
      MEM_REQ      <= req_d;
      MEM_WE       <= we_d;
      MEM_ADDR     <= maddr_d;
      MEM_WDATA    <= wdata_d;
      MEM_WSTRB    <= wstrb_d;
    end
  end

endmodule
